dsp_mac_sequencer: RTL and testbench
====================================

# dsp_mac_sequencer

Sequencer that drives the hard DSP MAC block's operand, coefficient and control pins for one dot-product job, and returns the accumulated 64-bit result. The host loads up to DEPTH coefficients, issues START with a length, streams operands through a valid/ready port, and receives the MAC result on a valid/ready result port. It sits between the fabric datapath and the DSP primitive and is the only driver of that primitive's inputs.

## Interface
- DEPTH, 16: coefficient slots; max job length.
- MAC_LATENCY, 2: cycles from a DSP_ENABLE-high cycle to the DSP_MAC_OUT reflecting it; ≥1.
- CLOCK  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CFG_WE  in  1  coefficient write strobe.
- CFG_ADDR  in  $clog2(DEPTH)  coefficient slot.
- CFG_DATA  in  32  coefficient value.
- START  in  1  job request, sampled in IDLE only.
- LEN  in  $clog2(DEPTH)+1  beats in job, legal 1..DEPTH.
- MODE  in  2  latched to DSP_MODE_SEL at START.
- OUT_SEL  in  2  latched to DSP_OUT_SEL at START.
- RND, SAT  in  1 each  latched to DSP_RND / DSP_SAT at START.
- BUSY  out  1  high in any state except IDLE.
- START_ERR  out  1  one-cycle pulse on illegal LEN.
- OPER_VALID  in  1 / OPER_DATA  in  32 / OPER_READY  out  1  operand stream.
- DSP_OPER, DSP_COEF  out  32 each  to DSP OPER_DATA / COEF_DATA.
- DSP_ENABLE, DSP_CLR  out  1 each  to DSP ENABLE / CLR.
- DSP_MODE_SEL, DSP_OUT_SEL  out  2 each; DSP_RND, DSP_SAT  out  1 each.
- DSP_MAC_OUT  in  64  from DSP MAC_OUT.
- RES_VALID  out  1 / RES_DATA  out  64 / RES_READY  in  1  result port.

## Operation
- All outputs registered; reset value 0 for every output, state IDLE, coefficient slots 0, counters 0.
- FSM: IDLE → CLEAR → STREAM → DRAIN → RESULT → IDLE.
- IDLE: CFG_WE writes CFG_DATA to slot CFG_ADDR. START with 1≤LEN≤DEPTH latches LEN, MODE, OUT_SEL, RND, SAT, index=0 → CLEAR. START with LEN=0 or LEN>DEPTH: stay IDLE, START_ERR pulses next cycle.
- CFG_WE outside IDLE ignored; START outside IDLE ignored.
- CLEAR: DSP_CLR=1, DSP_ENABLE=0 for exactly one cycle → STREAM.
- STREAM: OPER_READY=1. Handshake (VALID&READY) at cycle t: at t+1 DSP_OPER=OPER_DATA, DSP_COEF=coef[index], DSP_ENABLE=1; index++. No handshake: DSP_ENABLE=0 next cycle, DSP_OPER/DSP_COEF hold. After LEN-th handshake OPER_READY drops the next cycle → DRAIN.
- DRAIN: counts MAC_LATENCY cycles after the last DSP_ENABLE cycle; on final count RES_DATA ← DSP_MAC_OUT → RESULT.
- RESULT: RES_VALID=1, RES_DATA stable until RES_READY; on handshake RES_VALID=0 next cycle → IDLE. START in the handshake cycle is ignored.
- DSP_MODE_SEL/OUT_SEL/RND/SAT hold latched values until next legal START.
- RESET_N low mid-job: immediate abort, all outputs 0, coefficients cleared.

## Timing
- START cycle 0 → DSP_CLR high cycle 1 → OPER_READY high from cycle 2.
- No bubbles, LEN=N: handshakes cycles 2..N+1; DSP_ENABLE high cycles 3..N+2; RES_VALID rises cycle N+2+MAC_LATENCY+1.
- Each operand bubble delays RES_VALID by one cycle.
- Min job-to-job turnaround: one IDLE cycle after result handshake.

## Structure
- Package dsp_seq_pkg: state enum (IDLE, CLEAR, STREAM, DRAIN, RESULT), DSP mode-select and out-select encodings, width constants.
- Sub-module dsp_coef_rf: DEPTH×32 register file, sync write, async read, async active-low clear.

## Test plan
- Load coef[0..3]={1,2,3,4}; START LEN=4, operands {5,6,7,8}, no bubbles → DSP_ENABLE cycles 3..6 with coef/oper pairs (1,5),(2,6),(3,7),(4,8); RES_VALID at cycle 9 with RES_DATA = DSP model value 70.
- Same job, OPER_VALID low on cycle 3 → one DSP_ENABLE gap, RES_VALID at cycle 10, value 70.
- START LEN=0 and LEN=17 → START_ERR one-cycle pulse, BUSY stays 0, no DSP_CLR.
- RES_READY held low 5 cycles in RESULT → RES_VALID/RES_DATA stable; START and CFG_WE during that time ignored (coef readback unchanged).
- RESET_N asserted mid-STREAM at beat 2 → all outputs 0 asynchronously, IDLE; a fresh LEN=1 job then completes with coef 0 → result 0.
- LEN=16 (DEPTH), MAC_LATENCY=2 → index wraps cleanly, 16 enables, RES_VALID at cycle 21.

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP MAC sequencer.
// Holds the FSM state enum, DSP select encodings and width constants.
package dsp_seq_pkg;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 64;
    localparam int MODE_W = 2;
    localparam int OSEL_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        RESULT
    } state_t;

    // DSP MODE_SEL pin encodings.
    typedef enum logic [MODE_W-1:0] {
        MODE_MAC     = 2'b00,
        MODE_MACSUB  = 2'b01,
        MODE_MUL     = 2'b10,
        MODE_PRELOAD = 2'b11
    } dsp_mode_t;

    // DSP OUT_SEL pin encodings.
    typedef enum logic [OSEL_W-1:0] {
        OSEL_FULL  = 2'b00,
        OSEL_HIGH  = 2'b01,
        OSEL_LOW   = 2'b10,
        OSEL_SHIFT = 2'b11
    } dsp_osel_t;

    // A job length is legal when it fits in the coefficient file.
    function automatic logic len_ok(input int len, input int depth);
        return (len >= 1) && (len <= depth);
    endfunction

endpackage

// File: rtl/dsp_coef_rf.sv
// Coefficient register file: DEPTH x DATA_W, sync write, async read.
// Ports: clock, reset_n (async clear), we/waddr/wdata, raddr/rdata.
module dsp_coef_rf
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives the hard DSP MAC pins for one dot-product job per START.
// Ports: cfg write, job start, operand stream, DSP pins, result port.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int MAC_LATENCY = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic [LW-1:0]     len,
    input  logic [MODE_W-1:0] mode,
    input  logic [OSEL_W-1:0] out_sel,
    input  logic              rnd,
    input  logic              sat,
    output logic              busy,
    output logic              start_err,
    input  logic              oper_valid,
    input  logic [DATA_W-1:0] oper_data,
    output logic              oper_ready,
    output logic [DATA_W-1:0] dsp_oper,
    output logic [DATA_W-1:0] dsp_coef,
    output logic              dsp_enable,
    output logic              dsp_clr,
    output logic [MODE_W-1:0] dsp_mode_sel,
    output logic [OSEL_W-1:0] dsp_out_sel,
    output logic              dsp_rnd,
    output logic              dsp_sat,
    input  logic [ACC_W-1:0]  dsp_mac_out,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res_data,
    input  logic              res_ready
);

    localparam int CW =
        (MAC_LATENCY < 2) ? 1 : $clog2(MAC_LATENCY + 1);

    state_t state_q, state_d;

    logic [AW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] coef_rd;

    logic              busy_d;
    logic              start_err_d;
    logic              oper_ready_d;
    logic [DATA_W-1:0] dsp_oper_d;
    logic [DATA_W-1:0] dsp_coef_d;
    logic              dsp_enable_d;
    logic              dsp_clr_d;
    logic [MODE_W-1:0] mode_d;
    logic [OSEL_W-1:0] osel_d;
    logic              rnd_d;
    logic              sat_d;
    logic              res_valid_d;
    logic [ACC_W-1:0]  res_data_d;

    logic cfg_wr;
    logic oper_hs;
    logic last_beat;

    // The coefficient file is only writable between jobs.
    assign cfg_wr = cfg_we && (state_q == IDLE);

    dsp_coef_rf #(
        .DEPTH (DEPTH)
    ) u_coef_rf (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (cfg_wr),
        .waddr   (cfg_addr),
        .wdata   (cfg_data),
        .raddr   (idx_q),
        .rdata   (coef_rd)
    );

    assign oper_hs   = oper_valid && oper_ready;
    assign last_beat = ({1'b0, idx_q} == (len_q - LW'(1)));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        start_err_d  = 1'b0;
        oper_ready_d = 1'b0;
        dsp_oper_d   = dsp_oper;
        dsp_coef_d   = dsp_coef;
        dsp_enable_d = 1'b0;
        dsp_clr_d    = 1'b0;
        mode_d       = dsp_mode_sel;
        osel_d       = dsp_out_sel;
        rnd_d        = dsp_rnd;
        sat_d        = dsp_sat;
        res_valid_d  = res_valid;
        res_data_d   = res_data;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok(int'(len), DEPTH)) begin
                        len_d     = len;
                        idx_d     = '0;
                        mode_d    = mode;
                        osel_d    = out_sel;
                        rnd_d     = rnd;
                        sat_d     = sat;
                        dsp_clr_d = 1'b1;
                        state_d   = CLEAR;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                oper_ready_d = 1'b1;
                state_d      = STREAM;
            end
            STREAM: begin
                oper_ready_d = 1'b1;
                if (oper_hs) begin
                    dsp_enable_d = 1'b1;
                    dsp_oper_d   = oper_data;
                    dsp_coef_d   = coef_rd;
                    idx_d        = idx_q + AW'(1);
                    if (last_beat) begin
                        oper_ready_d = 1'b0;
                        cnt_d        = '0;
                        state_d      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // First DRAIN cycle is the last enable cycle, so the
                // accumulator is valid once cnt reaches MAC_LATENCY.
                if (cnt_q == CW'(MAC_LATENCY)) begin
                    res_data_d  = dsp_mac_out;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            busy         <= 1'b0;
            start_err    <= 1'b0;
            oper_ready   <= 1'b0;
            dsp_oper     <= '0;
            dsp_coef     <= '0;
            dsp_enable   <= 1'b0;
            dsp_clr      <= 1'b0;
            dsp_mode_sel <= '0;
            dsp_out_sel  <= '0;
            dsp_rnd      <= 1'b0;
            dsp_sat      <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            busy         <= busy_d;
            start_err    <= start_err_d;
            oper_ready   <= oper_ready_d;
            dsp_oper     <= dsp_oper_d;
            dsp_coef     <= dsp_coef_d;
            dsp_enable   <= dsp_enable_d;
            dsp_clr      <= dsp_clr_d;
            dsp_mode_sel <= mode_d;
            dsp_out_sel  <= osel_d;
            dsp_rnd      <= rnd_d;
            dsp_sat      <= sat_d;
            res_valid    <= res_valid_d;
            res_data     <= res_data_d;
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer with a behavioural DSP MAC.
// Stimulus pushes expected enables/results; a forked monitor checks.
module tb_dsp_mac_sequencer;

    localparam int L = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        start = 1'b0;
    logic [4:0]  len = '0;
    logic [1:0]  mode = '0;
    logic [1:0]  out_sel = '0;
    logic        rnd = 1'b0;
    logic        sat = 1'b0;
    logic        busy;
    logic        start_err;
    logic        oper_valid = 1'b0;
    logic [31:0] oper_data = '0;
    logic        oper_ready;
    logic [31:0] dsp_oper;
    logic [31:0] dsp_coef;
    logic        dsp_enable;
    logic        dsp_clr;
    logic [1:0]  dsp_mode_sel;
    logic [1:0]  dsp_out_sel;
    logic        dsp_rnd;
    logic        dsp_sat;
    logic [63:0] dsp_mac_out;
    logic        res_valid;
    logic [63:0] res_data;
    logic        res_ready = 1'b1;

    dsp_mac_sequencer #(
        .DEPTH       (16),
        .MAC_LATENCY (L)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .start        (start),
        .len          (len),
        .mode         (mode),
        .out_sel      (out_sel),
        .rnd          (rnd),
        .sat          (sat),
        .busy         (busy),
        .start_err    (start_err),
        .oper_valid   (oper_valid),
        .oper_data    (oper_data),
        .oper_ready   (oper_ready),
        .dsp_oper     (dsp_oper),
        .dsp_coef     (dsp_coef),
        .dsp_enable   (dsp_enable),
        .dsp_clr      (dsp_clr),
        .dsp_mode_sel (dsp_mode_sel),
        .dsp_out_sel  (dsp_out_sel),
        .dsp_rnd      (dsp_rnd),
        .dsp_sat      (dsp_sat),
        .dsp_mac_out  (dsp_mac_out),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ready    (res_ready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural DSP: accumulate, then one extra pipe stage (latency 2).
    logic [63:0] acc = '0;
    logic [63:0] acc_d1 = '0;
    always @(posedge clock) begin
        if (dsp_clr) acc <= '0;
        else if (dsp_enable) acc <= acc + dsp_oper * dsp_coef;
        acc_d1 <= acc;
    end
    assign dsp_mac_out = acc_d1;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } res_t;

    typedef struct {
        int          cyc;
        logic [31:0] coef;
        logic [31:0] oper;
    } en_t;

    res_t res_q[$];
    en_t  en_q[$];

    logic [31:0] tb_coef [16];
    logic [31:0] ops [16];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input logic [3:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
        tb_coef[a] = d;
    endtask

    task automatic run_job(input int n, input int gap_at,
                           input logic [63:0] exp, input int stall);
        int t0;
        int bub;
        bub = (gap_at >= 0) ? 1 : 0;
        res_ready = (stall == 0);
        start = 1'b1;
        len = 5'(n);
        t0 = cyc;
        res_q.push_back('{t0 + n + 2 + L + 1 + bub, exp});
        tick();
        start = 1'b0;
        check("clr_pulse", {62'd0, dsp_clr, busy}, 64'h3);
        check("latched_sel",
              {58'd0, dsp_mode_sel, dsp_out_sel, dsp_rnd, dsp_sat},
              {58'd0, mode, out_sel, rnd, sat});
        tick();
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                oper_valid = 1'b0;
                tick();
            end
            oper_valid = 1'b1;
            oper_data = ops[i];
            en_q.push_back('{cyc + 1, tb_coef[i], ops[i]});
            tick();
        end
        oper_valid = 1'b0;
        for (int k = 0; k < 50 && !res_valid; k++) tick();
        if (!res_valid) begin
            n_chk++;
            $display("FAIL res_timeout: res_valid never rose, job len %0d", n);
        end
        if (stall > 0) begin
            for (int s = 0; s < stall; s++) begin
                start = 1'b1;
                len = 5'd1;
                cfg_we = 1'b1;
                cfg_addr = 4'd0;
                cfg_data = 32'd99;
                tick();
                check("stall_ctl", {61'd0, res_valid, busy, dsp_clr},
                      64'h6);
            end
            res_ready = 1'b1;
            tick();
            start = 1'b0;
            cfg_we = 1'b0;
        end else begin
            tick();
        end
        check("after_hs", {62'd0, res_valid, busy}, 64'h0);
        tick();
        check("no_restart", {62'd0, busy, dsp_clr}, 64'h0);
        check("en_left", 64'(en_q.size()), 64'd0);
    endtask

    task automatic bad_len(input logic [4:0] l);
        start = 1'b1;
        len = l;
        tick();
        start = 1'b0;
        check("err_pulse", {61'd0, start_err, busy, dsp_clr}, 64'h4);
        tick();
        check("err_clear", {61'd0, start_err, busy, dsp_clr}, 64'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"},
              {50'd0, busy, start_err, oper_ready, dsp_enable, dsp_clr,
               dsp_mode_sel, dsp_out_sel, dsp_rnd, dsp_sat, res_valid},
              64'd0);
        check({tag, "_dsp"}, {dsp_oper, dsp_coef}, 64'd0);
        check({tag, "_res"}, res_data, 64'd0);
    endtask

    initial begin
        logic prev_valid;
        logic [63:0] held;
        res_t r;
        en_t e;

        for (int i = 0; i < 16; i++) begin
            tb_coef[i] = '0;
            ops[i] = '0;
        end

        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        prev_valid = 1'b0;
        held = '0;
        fork
            forever begin
                @(negedge clock);
                if (!reset_n) begin
                    prev_valid = 1'b0;
                end else begin
                    if (dsp_enable) begin
                        if (en_q.size() == 0) begin
                            n_chk++;
                            $display("FAIL en_extra: enable at cycle %0d", cyc);
                        end else begin
                            e = en_q.pop_front();
                            check("en_cyc", 64'(cyc), 64'(e.cyc));
                            check("en_coef", 64'(dsp_coef), 64'(e.coef));
                            check("en_oper", 64'(dsp_oper), 64'(e.oper));
                        end
                    end
                    if (res_valid && !prev_valid) begin
                        if (res_q.size() == 0) begin
                            n_chk++;
                            $display("FAIL res_extra: result at cycle %0d", cyc);
                        end else begin
                            r = res_q.pop_front();
                            check("res_cyc", 64'(cyc), 64'(r.cyc));
                            check("res_data", res_data, r.data);
                        end
                        held = res_data;
                    end else if (res_valid) begin
                        check("res_hold", res_data, held);
                    end
                    prev_valid = res_valid;
                end
            end
        join_none

        cfg(4'd0, 32'd1);
        cfg(4'd1, 32'd2);
        cfg(4'd2, 32'd3);
        cfg(4'd3, 32'd4);
        ops[0] = 32'd5;
        ops[1] = 32'd6;
        ops[2] = 32'd7;
        ops[3] = 32'd8;

        mode = 2'b01; out_sel = 2'b10; rnd = 1'b1; sat = 1'b0;
        run_job(4, -1, 64'd70, 0);

        mode = 2'b11; out_sel = 2'b01; rnd = 1'b0; sat = 1'b1;
        run_job(4, 1, 64'd70, 0);

        mode = 2'b10; out_sel = 2'b11; rnd = 1'b1; sat = 1'b1;
        run_job(4, -1, 64'd70, 5);
        check("sel_held", {60'd0, dsp_mode_sel, dsp_out_sel}, 64'hb);

        mode = 2'b00; out_sel = 2'b00; rnd = 1'b0; sat = 1'b0;
        run_job(4, -1, 64'd70, 0);

        bad_len(5'd0);
        bad_len(5'd17);

        for (int i = 0; i < 16; i++) begin
            cfg(4'(i), 32'(i + 1));
            ops[i] = 32'(i + 1);
        end
        run_job(16, -1, 64'd1496, 0);

        ops[0] = 32'd5;
        ops[1] = 32'd6;
        mode = 2'b01; out_sel = 2'b01; rnd = 1'b1; sat = 1'b1;
        start = 1'b1;
        len = 5'd4;
        tick();
        start = 1'b0;
        tick();
        oper_valid = 1'b1;
        oper_data = ops[0];
        en_q.push_back('{cyc + 1, tb_coef[0], ops[0]});
        tick();
        oper_data = ops[1];
        tick();
        oper_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) tb_coef[i] = '0;
        tick();
        check("abort_en_left", 64'(en_q.size()), 64'd0);

        ops[0] = 32'd5;
        mode = 2'b00; out_sel = 2'b00; rnd = 1'b0; sat = 1'b0;
        run_job(1, -1, 64'd0, 0);

        check("res_left", 64'(res_q.size()), 64'd0);
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
